// File: rtl/shift_cmd_queue.sv
// Command FIFO and registered result stage wrapped around an external 8-bit combinational barrel shifter.
// Optional output handshake counter (done_cnt) is enabled by defining SHIFT_CMD_CNT_EN.
module shift_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_din,
  input  logic [2:0] in_shamt,
  input  logic       in_dir,
  input  logic       in_op,
  output logic [7:0] bs_din,
  output logic [2:0] bs_shamt,
  output logic       bs_dir,
  output logic       bs_op,
  input  logic [7:0] bs_dout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [1:0] out_code
`ifdef SHIFT_CMD_CNT_EN
  ,
  output logic [15:0] done_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry layout: {din[7:0], shamt[2:0], op, dir}
  logic [12:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic [1:0]    out_code_q, out_code_d;
  logic [12:0]   head;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  always_comb begin
    fifo_empty = (count_q == '0);
    in_ready   = (count_q != CW'(DEPTH));
    push       = in_valid && in_ready;
    pop        = !fifo_empty && (!out_valid_q || out_ready);

    // Shifter sees zeros when idle so its inputs never toggle on stale entries
    head = fifo_empty ? 13'd0 : mem_q[rd_ptr_q];
    {bs_din, bs_shamt, bs_op, bs_dir} = head;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_code_d  = out_code_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = bs_dout;
      out_code_d  = {head[1], head[0]};
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Storage carries no reset; the pointers and count define which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_din, in_shamt, in_op, in_dir};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_code_q  <= 2'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_code_q  <= out_code_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_code  = out_code_q;

`ifdef SHIFT_CMD_CNT_EN
  logic [15:0] done_cnt_q, done_cnt_d;

  always_comb begin
    done_cnt_d = done_cnt_q + 16'(out_valid_q && out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q <= 16'd0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign done_cnt = done_cnt_q;
`endif

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Scoreboard bench for shift_cmd_queue with a behavioural barrel shifter on the bs_* loop.
module tb_shift_cmd_queue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_din;
  logic [2:0] in_shamt;
  logic       in_dir;
  logic       in_op;
  logic [7:0] bs_din;
  logic [2:0] bs_shamt;
  logic       bs_dir;
  logic       bs_op;
  logic [7:0] bs_dout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_code;
`ifdef SHIFT_CMD_CNT_EN
  logic [15:0] done_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;
  logic [9:0] sb [$];

  always #5 clk = ~clk;

  shift_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_din    (in_din),
    .in_shamt  (in_shamt),
    .in_dir    (in_dir),
    .in_op     (in_op),
    .bs_din    (bs_din),
    .bs_shamt  (bs_shamt),
    .bs_dir    (bs_dir),
    .bs_op     (bs_op),
    .bs_dout   (bs_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_code  (out_code)
`ifdef SHIFT_CMD_CNT_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  // dir=1 shifts left; dir=0 shifts right, arithmetic when op=1
  function automatic logic [7:0] shift_model(input logic [7:0] d, input logic [2:0] s,
                                             input logic op, input logic dir);
    if (dir) return d << s;
    else if (op) return 8'($signed(d) >>> s);
    else return d >> s;
  endfunction

  always_comb bs_dout = shift_model(bs_din, bs_shamt, bs_op, bs_dir);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Handshakes are observed mid-cycle; inputs and registered outputs are stable here
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          check("sb_underflow", 16'(out_data), 16'hFFFF);
        end else begin
          logic [9:0] e;
          e = sb.pop_front();
          check("out_data", 16'(out_data), 16'(e[7:0]));
          check("out_code", 16'(out_code), 16'(e[9:8]));
          $display("result data=%02h code=%0b", out_data, out_code);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_op, in_dir, shift_model(in_din, in_shamt, in_op, in_dir)});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [7:0] d, input logic [2:0] s, input logic op, input logic dir);
    in_valid = 1'b1;
    in_din   = d;
    in_shamt = s;
    in_op    = op;
    in_dir   = dir;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_din   = 8'($urandom);
    in_shamt = 3'($urandom);
    in_op    = 1'($urandom);
    in_dir   = 1'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    hs_cnt = 0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle_in();
    #1;
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_out_data", 16'(out_data), 16'h0);
    check("rst_out_code", 16'(out_code), 16'h0);
    check("rst_bs_din", 16'(bs_din), 16'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 16'(in_ready), 16'h1);
`ifdef SHIFT_CMD_CNT_EN
    check("rst_done_cnt", done_cnt, 16'h0);
`endif

    // Latency: push at edge N, visible on shifter during N+1, captured at N+1
    out_ready = 1'b1;
    drive_cmd(8'hB4, 3'd3, 1'b0, 1'b0);
    step();
    idle_in();
    check("lat_valid_n", 16'(out_valid), 16'h0);
    check("lat_bs_din", 16'(bs_din), 16'hB4);
    check("lat_bs_shamt", 16'(bs_shamt), 16'h3);
    step();
    check("lat_valid_n1", 16'(out_valid), 16'h1);
    check("lat_data", 16'(out_data), 16'h16);
    check("lat_code", 16'(out_code), 16'h0);
    step();
    check("lat_valid_after", 16'(out_valid), 16'h0);

    // Back-to-back commands produce results on consecutive cycles
    drive_cmd(8'hB4, 3'd3, 1'b1, 1'b0);
    step();
    drive_cmd(8'hB4, 3'd2, 1'b0, 1'b1);
    step();
    check("b2b_valid0", 16'(out_valid), 16'h1);
    check("b2b_data0", 16'(out_data), 16'hF6);
    drive_cmd(8'h81, 3'd0, 1'b1, 1'b1);
    step();
    idle_in();
    check("b2b_valid1", 16'(out_valid), 16'h1);
    check("b2b_data1", 16'(out_data), 16'hD0);
    step();
    check("b2b_valid2", 16'(out_valid), 16'h1);
    check("b2b_code2", 16'(out_code), 16'h3);
    step();
    check("b2b_idle", 16'(out_valid), 16'h0);

    // Backpressure: fill output register plus DEPTH FIFO entries
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive_cmd(8'(k), 3'd0, 1'b0, 1'b0);
      step();
    end
    drive_cmd(8'h06, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("full_in_ready", 16'(in_ready), 16'h0);
      check("full_hold_data", 16'(out_data), 16'h01);
      check("full_out_valid", 16'(out_valid), 16'h1);
      step();
    end
    check("full_head", 16'(bs_din), 16'h02);
    out_ready = 1'b1;
    step();
    check("full_ready_back", 16'(in_ready), 16'h1);
    step();
    idle_in();
    for (int k = 0; k < 8; k++) step();
    check("full_drained", 16'(out_valid), 16'h0);
    check("full_sb_empty", 16'(sb.size()), 16'h0);

    // Simultaneous push and pop with two entries queued
    out_ready = 1'b0;
    drive_cmd(8'h11, 3'd1, 1'b0, 1'b1);
    step();
    drive_cmd(8'h22, 3'd1, 1'b0, 1'b1);
    step();
    drive_cmd(8'h33, 3'd1, 1'b0, 1'b1);
    step();
    check("pp_count_before", 16'(dut.count_q), 16'h2);
    drive_cmd(8'h44, 3'd1, 1'b0, 1'b1);
    out_ready = 1'b1;
    step();
    idle_in();
    out_ready = 1'b0;
    check("pp_count_after", 16'(dut.count_q), 16'h2);
    check("pp_head", 16'(bs_din), 16'h33);
    check("pp_out_data", 16'(out_data), 16'h44);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    check("pp_sb_empty", 16'(sb.size()), 16'h0);

    // Asynchronous reset mid-cycle discards queued and pending work
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_cmd(8'hA0 + 8'(k), 3'd1, 1'b1, 1'b0);
      step();
    end
    idle_in();
    check("mr_valid_pre", 16'(out_valid), 16'h1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    hs_cnt = 0;
    #1;
    check("mr_out_valid", 16'(out_valid), 16'h0);
    check("mr_out_data", 16'(out_data), 16'h0);
    check("mr_in_ready", 16'(in_ready), 16'h1);
    check("mr_bs", 16'({bs_din, bs_shamt, bs_op, bs_dir}), 16'h0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive_cmd(8'h5A, 3'd4, 1'b0, 1'b0);
    step();
    idle_in();
    for (int k = 0; k < 6; k++) step();
    check("mr_sb_empty", 16'(sb.size()), 16'h0);
    check("mr_one_result", 16'(hs_cnt), 16'h1);

`ifdef SHIFT_CMD_CNT_EN
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_cmd(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    idle_in();
    for (int k = 0; k < 4; k++) step();
    check("cnt_five", done_cnt, 16'd5);
    for (int k = 0; k < 65530; k++) begin
      drive_cmd(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    idle_in();
    for (int k = 0; k < 4; k++) step();
    check("cnt_max", done_cnt, 16'hFFFF);
    drive_cmd(8'h01, 3'd0, 1'b0, 1'b0);
    step();
    idle_in();
    for (int k = 0; k < 4; k++) step();
    check("cnt_wrap", done_cnt, 16'h0000);
`endif

    check("final_sb_empty", 16'(sb.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
